mult3_seq_ctrl: RTL and testbench
=================================

Name: mult3_seq_ctrl

Overview:
- Multi-cycle controller that computes a wide unsigned product by time-sharing one external 3x3 combinational array multiplier (6-bit product).
- Operands are split into 3-bit digits. Digit pairs are fed to the shared multiplier one per cycle, and the shifted partial products are accumulated.
- Sits between a valid/ready requester and the multiplier instance. It owns the multiplier inputs and reads the multiplier output.

Parameters:
- DIGITS, 2, number of 3-bit digits per operand; operand width W = 3*DIGITS, product width 2*W; legal range 1..4

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  operand pair valid
- in_ready  out  1  controller can accept operands
- a  in  W  multiplicand, unsigned
- b  in  W  multiplier, unsigned
- mul_a  out  3  digit to shared multiplier A input
- mul_b  out  3  digit to shared multiplier B input
- mul_p  in  6  shared multiplier product, combinational from mul_a/mul_b in the same cycle
- out_valid  out  1  product valid
- out_ready  in  1  consumer accepts product
- product  out  2*W  registered result
- busy  out  1  high in MUL or DONE

Behaviour:
- Reset (async, active-high) forces:
  - state=IDLE, step=0, acc=0, operand regs=0, product=0, out_valid=0.
  - in_ready then reads 1, busy 0, mul_a=mul_b=0.
  - Reset mid-operation discards the operation; no partial result is ever presented.
- States: IDLE, MUL, DONE.
- IDLE:
  - in_ready=1.
  - On a clock edge with in_valid=1: capture a, b into operand regs, set acc=0, step=0, go to MUL.
- MUL:
  - in_ready=0.
  - Digit indices: i = step / DIGITS, j = step mod DIGITS.
  - mul_a = a_reg[3i+2:3i], mul_b = b_reg[3j+2:3j].
  - Each edge: acc <= acc + (mul_p << 3*(i+j)), truncated to 2*W (no overflow is possible), step <= step+1.
  - On the edge where step = DIGITS²-1: perform the final accumulate, load product with the final sum, set out_valid=1, go to DONE.
  - Exactly DIGITS² MUL cycles; no early termination on zero digits.
- DONE:
  - out_valid=1, product stable, in_ready=0, mul_a=mul_b=0.
  - On an edge with out_ready=1: out_valid<=0, go to IDLE.
  - product holds its value until the next completion; it is not cleared on handoff.
- Latency:
  - If operands are accepted at edge E0, out_valid rises after edge E(DIGITS²). This is 4 cycles for DIGITS=2.
  - Minimum initiation interval is DIGITS²+2 cycles: accept, DIGITS² MUL cycles, one handoff cycle, then IDLE.
- Handshake rules:
  - No acceptance while busy.
  - in_valid asserted during MUL/DONE is ignored; the requester must hold it until in_ready.
  - Operand changes after acceptance have no effect.
  - out_ready while out_valid=0 has no effect.
- mul_a/mul_b are 0 in IDLE and DONE so the shared multiplier does not toggle.

Test Plan:
- DIGITS=2, a=6'h3F, b=6'h3F, out_ready=1 → out_valid 4 cycles after acceptance, product=12'hF81 (3969), held exactly one cycle, then in_ready=1.
- DIGITS=2, a=5, b=3, then a=0, b=6'h2A back-to-back with in_valid held high → products 15 then 0; second acceptance occurs 6 cycles after the first.
- Backpressure: a=6'h24, b=6'h12, out_ready=0 for 5 cycles after out_valid → product=12'h288 stable, out_valid high, in_ready low; new in_valid ignored; release → IDLE next cycle.
- Reset asserted asynchronously during the 2nd MUL cycle of a=6'h3F, b=6'h01 → out_valid=0, product=0, in_ready=1 immediately; no result appears after reset is released.
- Digit sequencing for a=6'o21, b=6'o43: mul_a/mul_b sequence (1,3),(1,4),(2,3),(2,4) → product=17*35=595.
- DIGITS=1, a=7, b=7 → one MUL cycle, product=6'd49, out_valid after the 1st edge following acceptance.

Source files
------------

// File: rtl/mult3_seq_ctrl.sv
// Sequential wide multiplier that time-shares one external 3x3 array multiplier.
// Operands are split into 3-bit digits and partial products accumulated per cycle.
module mult3_seq_ctrl #(
    parameter int DIGITS = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [3*DIGITS-1:0]   a,
    input  logic [3*DIGITS-1:0]   b,
    output logic [2:0]            mul_a,
    output logic [2:0]            mul_b,
    input  logic [5:0]            mul_p,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [6*DIGITS-1:0]   product,
    output logic                  busy
);

    localparam int W  = 3 * DIGITS;
    localparam int PW = 2 * W;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [IW-1:0] D_LAST = IW'(DIGITS - 1);

    logic [1:0]             state;
    logic [IW-1:0]          di;
    logic [IW-1:0]          dj;
    logic [DIGITS-1:0][2:0] a_reg;
    logic [DIGITS-1:0][2:0] b_reg;
    logic [PW-1:0]          acc;
    logic [PW-1:0]          pp;
    logic [PW-1:0]          sum;
    logic                   last;

    // Digits are only driven in MUL so the shared multiplier stays quiet otherwise
    always_comb begin
        mul_a = 3'd0;
        mul_b = 3'd0;
        if (state == S_MUL) begin
            mul_a = a_reg[di];
            mul_b = b_reg[dj];
        end
    end

    assign pp   = PW'(mul_p) << (3 * (32'(di) + 32'(dj)));
    assign sum  = acc + pp;
    assign last = (di == D_LAST) && (dj == D_LAST);

    assign in_ready = (state == S_IDLE);
    assign busy     = (state == S_MUL) || (state == S_DONE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            di        <= '0;
            dj        <= '0;
            a_reg     <= '0;
            b_reg     <= '0;
            acc       <= '0;
            product   <= '0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        a_reg <= a;
                        b_reg <= b;
                        acc   <= '0;
                        di    <= '0;
                        dj    <= '0;
                        state <= S_MUL;
                    end
                end
                S_MUL: begin
                    acc <= sum;
                    if (last) begin
                        product   <= sum;
                        out_valid <= 1'b1;
                        state     <= S_DONE;
                    end else if (dj == D_LAST) begin
                        dj <= '0;
                        di <= di + 1'b1;
                    end else begin
                        dj <= dj + 1'b1;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    state     <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult3_seq_ctrl.sv
// Directed bench for mult3_seq_ctrl: DIGITS=2 main instance plus DIGITS=1 instance.
// Each instance drives its own behavioural 3x3 multiplier.
module tb_mult3_seq_ctrl;

    logic        clk;
    logic        reset;

    logic        in_valid;
    logic        in_ready;
    logic [5:0]  a;
    logic [5:0]  b;
    logic [2:0]  mul_a;
    logic [2:0]  mul_b;
    logic [5:0]  mul_p;
    logic        out_valid;
    logic        out_ready;
    logic [11:0] product;
    logic        busy;

    logic        in_valid1;
    logic        in_ready1;
    logic [2:0]  a1;
    logic [2:0]  b1;
    logic [2:0]  mul_a1;
    logic [2:0]  mul_b1;
    logic [5:0]  mul_p1;
    logic        out_valid1;
    logic        out_ready1;
    logic [5:0]  product1;
    logic        busy1;

    int total;
    int bad;
    int n;
    logic seen;

    assign mul_p  = 6'(mul_a) * 6'(mul_b);
    assign mul_p1 = 6'(mul_a1) * 6'(mul_b1);

    mult3_seq_ctrl #(.DIGITS(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .mul_a     (mul_a),
        .mul_b     (mul_b),
        .mul_p     (mul_p),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product),
        .busy      (busy)
    );

    mult3_seq_ctrl #(.DIGITS(1)) dut1 (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid1),
        .in_ready  (in_ready1),
        .a         (a1),
        .b         (b1),
        .mul_a     (mul_a1),
        .mul_b     (mul_b1),
        .mul_p     (mul_p1),
        .out_valid (out_valid1),
        .out_ready (out_ready1),
        .product   (product1),
        .busy      (busy1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic wait_out(output int cnt);
        cnt = 0;
        while (!out_valid && cnt < 40) begin
            tick();
            cnt++;
        end
    endtask

    logic [2:0] exp_ma [4];
    logic [2:0] exp_mb [4];

    initial begin
        total = 0;
        bad = 0;
        reset = 1'b1;
        in_valid = 1'b0;
        a = '0;
        b = '0;
        out_ready = 1'b1;
        in_valid1 = 1'b0;
        a1 = '0;
        b1 = '0;
        out_ready1 = 1'b1;
        exp_ma = '{3'd1, 3'd1, 3'd2, 3'd2};
        exp_mb = '{3'd3, 3'd4, 3'd3, 3'd4};

        repeat (2) tick();
        chk("rst_in_ready", 32'(in_ready), 1);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_product", 32'(product), 0);
        chk("rst_mul_ab", {26'd0, mul_a, mul_b}, 0);
        reset = 1'b0;
        tick();

        // Max operands, immediate consumer
        a = 6'h3F;
        b = 6'h3F;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("t1_busy", 32'(busy), 1);
        chk("t1_in_ready", 32'(in_ready), 0);
        wait_out(n);
        chk("t1_latency", 32'(n), 4);
        chk("t1_product", 32'(product), 32'hF81);
        chk("t1_mul_idle", {26'd0, mul_a, mul_b}, 0);
        tick();
        chk("t1_ov_drop", 32'(out_valid), 0);
        chk("t1_in_ready2", 32'(in_ready), 1);
        chk("t1_hold", 32'(product), 32'hF81);

        // Back-to-back with in_valid held high
        a = 6'd5;
        b = 6'd3;
        in_valid = 1'b1;
        tick();
        a = 6'd0;
        b = 6'h2A;
        wait_out(n);
        chk("t2_lat1", 32'(n), 4);
        chk("t2_prod1", 32'(product), 15);
        tick();
        chk("t2_idle", 32'(in_ready), 1);
        tick();
        chk("t2_accept6", 32'(busy), 1);
        in_valid = 1'b0;
        wait_out(n);
        chk("t2_lat2", 32'(n), 4);
        chk("t2_prod2", 32'(product), 0);
        tick();

        // Backpressure
        out_ready = 1'b0;
        a = 6'h24;
        b = 6'h12;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        wait_out(n);
        chk("t3_lat", 32'(n), 4);
        a = 6'd1;
        b = 6'd1;
        in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            chk("t3_prod", 32'(product), 32'h288);
            chk("t3_ov", 32'(out_valid), 1);
            chk("t3_in_ready", 32'(in_ready), 0);
            tick();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("t3_release_ov", 32'(out_valid), 0);
        chk("t3_release_rdy", 32'(in_ready), 1);
        chk("t3_prod_kept", 32'(product), 32'h288);

        // Async reset during the second MUL cycle
        a = 6'h3F;
        b = 6'h01;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        #2;
        reset = 1'b1;
        #1;
        chk("t4_ov", 32'(out_valid), 0);
        chk("t4_prod", 32'(product), 0);
        chk("t4_in_ready", 32'(in_ready), 1);
        chk("t4_busy", 32'(busy), 0);
        #3;
        reset = 1'b0;
        seen = 1'b0;
        repeat (8) begin
            tick();
            if (out_valid) seen = 1'b1;
        end
        chk("t4_no_result", 32'(seen), 0);

        // Digit sequencing, octal 21 x 43
        a = 6'o21;
        b = 6'o43;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk("t5_mul_a", 32'(mul_a), 32'(exp_ma[k]));
            chk("t5_mul_b", 32'(mul_b), 32'(exp_mb[k]));
            tick();
        end
        chk("t5_ov", 32'(out_valid), 1);
        chk("t5_prod", 32'(product), 595);
        tick();

        // Single-digit instance
        a1 = 3'd7;
        b1 = 3'd7;
        in_valid1 = 1'b1;
        tick();
        in_valid1 = 1'b0;
        chk("t6_mul", {26'd0, mul_a1, mul_b1}, {26'd0, 3'd7, 3'd7});
        chk("t6_ov0", 32'(out_valid1), 0);
        tick();
        chk("t6_ov1", 32'(out_valid1), 1);
        chk("t6_prod", 32'(product1), 49);
        tick();
        chk("t6_idle", 32'(in_ready1), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
